// File: rtl/edge_counter_multi_pkg.sv
// Shared types for the multi-channel gated edge counter.
//   ec_op_t     : command opcodes carried in cmd_in[63:60]
//   ec_mode_t   : per-channel edge qualification mode
//   ec_record_t : 128-bit record written into the RTI FIFO
package edge_counter_pkg;

    localparam int unsigned TS_W      = 64;
    localparam int unsigned CH_W      = 4;
    localparam int unsigned REC_CNT_W = 56;

    // Bit offsets of the record fields inside count_out
    localparam int unsigned REC_TS_LSB   = 64;
    localparam int unsigned REC_CH_LSB   = 60;
    localparam int unsigned REC_SAT_BIT  = 59;
    localparam int unsigned REC_LOST_BIT = 58;
    localparam int unsigned REC_MODE_LSB = 56;

    typedef enum logic [3:0] {
        OP_START    = 4'h1,
        OP_STOP     = 4'h2,
        OP_SNAPSHOT = 4'h3,
        OP_CLEAR    = 4'h4,
        OP_SET_MODE = 4'h5
    } ec_op_t;

    typedef enum logic [1:0] {
        MODE_RISING   = 2'b00,
        MODE_FALLING  = 2'b01,
        MODE_BOTH     = 2'b10,
        MODE_BOTH_ALT = 2'b11
    } ec_mode_t;

    typedef struct packed {
        logic [TS_W-1:0]      ts;
        logic [CH_W-1:0]      ch;
        logic                 sat;
        logic                 lost;
        ec_mode_t             mode;
        logic [REC_CNT_W-1:0] count;
    } ec_record_t;

endpackage

// File: rtl/edge_counter_multi_if.sv
// Command / FIFO-side bus of edge_counter_multi.
//   master : command source and FIFO model (drives cmd_in, valid, counter, fifo_full)
//   slave  : the counter block (drives write, count_out, busy)
interface edge_counter_multi_if;

    logic [63:0]  cmd_in;
    logic         valid;
    logic [63:0]  counter;
    logic         fifo_full;
    logic         write;
    logic [127:0] count_out;
    logic         busy;

    modport master (
        output cmd_in, valid, counter, fifo_full,
        input  write, count_out, busy
    );

    modport slave (
        input  cmd_in, valid, counter, fifo_full,
        output write, count_out, busy
    );

endinterface

// File: rtl/edge_counter_multi_ec_channel.sv
// One counter channel: input synchroniser, edge detector, saturating counter
// and a single pending-record slot.
//   sig_in      : asynchronous input
//   start_i..   : decoded command strobes for this channel
//   mode_i/ts_i : new edge mode and command-cycle timestamp
//   grant_i     : arbiter is writing this channel's slot this cycle
//   pending_o   : slot holds an unwritten record
//   rec_o       : slot contents
module ec_channel
    import edge_counter_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CH_IDX      = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sig_in,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic            snap_i,
    input  logic            clear_i,
    input  logic            set_mode_i,
    input  ec_mode_t        mode_i,
    input  logic [TS_W-1:0] ts_i,
    input  logic            grant_i,
    output logic            pending_o,
    output ec_record_t      rec_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;
    ec_mode_t               mode_q, mode_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   sat_q, sat_d;
    logic                   pend_q, pend_d;
    ec_record_t             slot_q, slot_d;
    logic                   sync_out_c;
    logic                   hit_c;

    // Edge qualification, counting and slot capture
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], sig_in};
        sync_out_c = sync_q[SYNC_STAGES-1];
        prev_d     = sync_out_c;
        armed_d    = armed_q;
        mode_d     = mode_q;
        count_d    = count_q;
        sat_d      = sat_q;
        pend_d     = pend_q;
        slot_d     = slot_q;

        case (mode_q)
            MODE_RISING:  hit_c = sync_out_c & ~prev_q;
            MODE_FALLING: hit_c = ~sync_out_c & prev_q;
            default:      hit_c = sync_out_c ^ prev_q;
        endcase

        if (start_i) begin
            armed_d = 1'b1;
        end else if (stop_i) begin
            armed_d = 1'b0;
        end

        if (set_mode_i) begin
            mode_d = mode_i;
        end

        // A same-cycle reset of the count wins over the edge
        if (start_i || clear_i || stop_i) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (armed_q && hit_c) begin
            if (&count_q) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end

        if (grant_i) begin
            pend_d = 1'b0;
        end

        // Capture uses pre-edge values; a slot being written this cycle counts as free
        if (stop_i || snap_i) begin
            pend_d       = 1'b1;
            slot_d.ts    = ts_i;
            slot_d.ch    = CH_W'(CH_IDX);
            slot_d.sat   = sat_q;
            slot_d.lost  = pend_q & ~grant_i;
            slot_d.mode  = mode_q;
            slot_d.count = REC_CNT_W'(count_q);
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            mode_q  <= MODE_RISING;
            count_q <= '0;
            sat_q   <= 1'b0;
            pend_q  <= 1'b0;
            slot_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            pend_q  <= pend_d;
            slot_q  <= slot_d;
        end
    end

    assign pending_o = pend_q;
    assign rec_o     = slot_q;

endmodule

// File: rtl/edge_counter_multi.sv
// Multi-channel gated edge counter between GPO command path and RTI FIFO.
//   clk, reset : system clock, synchronous active-high reset
//   input_sig  : NUM_CH asynchronous inputs to count
//   bus        : cmd_in/valid/counter in, fifo_full in, write/count_out/busy out
module edge_counter_multi
    import edge_counter_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] input_sig,
    edge_counter_multi_if.slave bus
);

    localparam int unsigned SUM_W = CH_W + 1;

    ec_op_t              op_c;
    ec_mode_t            mode_c;
    logic [NUM_CH-1:0]   mask_c, start_c, stop_c, snap_c, clear_c, setm_c;
    logic [NUM_CH-1:0]   pending_c, grant_c, rot_c;
    logic [2*NUM_CH-1:0] pend2_c;
    ec_record_t          recs_c [NUM_CH];
    ec_record_t          rec_sel_c;
    logic                found_c, do_wr_c;
    logic [CH_W-1:0]     off_c, sel_c;
    logic [SUM_W-1:0]    sum_c;
    logic                write_q, write_d;
    logic [127:0]        count_out_q, count_out_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic                unused_cmd_bits;

    assign unused_cmd_bits = ^{bus.cmd_in[59:18], bus.cmd_in[15:0]};

    // Command decode into per-channel strobes
    always_comb begin
        op_c    = ec_op_t'(bus.cmd_in[63:60]);
        mode_c  = ec_mode_t'(bus.cmd_in[17:16]);
        mask_c  = bus.valid ? bus.cmd_in[NUM_CH-1:0] : '0;
        start_c = (op_c == OP_START)    ? mask_c : '0;
        stop_c  = (op_c == OP_STOP)     ? mask_c : '0;
        snap_c  = (op_c == OP_SNAPSHOT) ? mask_c : '0;
        clear_c = (op_c == OP_CLEAR)    ? mask_c : '0;
        setm_c  = (op_c == OP_SET_MODE) ? mask_c : '0;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ec_channel #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .CH_IDX      (g)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .sig_in     (input_sig[g]),
            .start_i    (start_c[g]),
            .stop_i     (stop_c[g]),
            .snap_i     (snap_c[g]),
            .clear_i    (clear_c[g]),
            .set_mode_i (setm_c[g]),
            .mode_i     (mode_c),
            .ts_i       (bus.counter),
            .grant_i    (grant_c[g]),
            .pending_o  (pending_c[g]),
            .rec_o      (recs_c[g])
        );
    end

    // Round-robin pick: rotate pending so the channel after last_q lands at bit 0
    always_comb begin
        pend2_c = {pending_c, pending_c};
        rot_c   = NUM_CH'(pend2_c >> ({1'b0, last_q} + SUM_W'(1)));
        found_c = 1'b0;
        off_c   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot_c[i]) begin
                found_c = 1'b1;
                off_c   = CH_W'(i);
            end
        end
        sum_c = {1'b0, last_q} + {1'b0, off_c} + SUM_W'(1);
        if (sum_c >= SUM_W'(NUM_CH)) begin
            sum_c = sum_c - SUM_W'(NUM_CH);
        end
        sel_c   = CH_W'(sum_c);
        do_wr_c = found_c && !bus.fifo_full;

        grant_c   = '0;
        rec_sel_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_c == CH_W'(i)) begin
                rec_sel_c  = recs_c[i];
                grant_c[i] = do_wr_c;
            end
        end

        write_d     = do_wr_c;
        count_out_d = do_wr_c ? rec_sel_c : count_out_q;
        last_d      = do_wr_c ? sel_c : last_q;
    end

    // Output registers; last_q starts at the top channel so channel 0 goes first
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q     <= 1'b0;
            count_out_q <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
        end else begin
            write_q     <= write_d;
            count_out_q <= count_out_d;
            last_q      <= last_d;
        end
    end

    assign bus.write     = write_q;
    assign bus.count_out = count_out_q;
    assign bus.busy      = |pending_c;

endmodule

// File: tb/tb_edge_counter_multi.sv
// Scoreboard bench for edge_counter_multi: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_edge_counter_multi;
    import edge_counter_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int CW      = 4;
    localparam int SYNC    = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] sig;

    edge_counter_multi_if bus_if();

    edge_counter_multi #(
        .NUM_CH      (NUM_CH),
        .COUNT_WIDTH (CW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .input_sig (sig),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    // Model state
    logic [NUM_CH-1:0] hist[$];
    bit                m_armed [NUM_CH];
    int                m_mode  [NUM_CH];
    int                m_count [NUM_CH];
    bit                m_sat   [NUM_CH];
    logic [127:0]      m_rec   [NUM_CH];
    logic [NUM_CH-1:0] m_pend;
    int                m_last;
    logic [127:0]      m_hold;
    bit                m_wr;

    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    int           got_cyc[$];

    function automatic logic [127:0] make_rec(input logic [63:0] ts, input int ch, input bit sat,
                                              input bit lost, input int mode, input int cnt);
        logic [127:0] r;
        r = '0;
        r[REC_TS_LSB +: 64]  = ts;
        r[REC_CH_LSB +: 4]   = 4'(ch);
        r[REC_SAT_BIT]       = sat;
        r[REC_LOST_BIT]      = lost;
        r[REC_MODE_LSB +: 2] = 2'(mode);
        r[31:0]              = 32'(cnt);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Behavioural reference: what the block does at one rising edge
    task automatic model_step();
        logic [NUM_CH-1:0] s_now, s_prev, m;
        logic [3:0]        op;
        bit                h;
        m_wr = 1'b0;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_armed[i] = 0; m_mode[i] = 0; m_count[i] = 0; m_sat[i] = 0; m_rec[i] = '0;
            end
            m_pend = '0;
            m_last = NUM_CH - 1;
            m_hold = '0;
            hist.delete();
            repeat (SYNC + 2) hist.push_back('0);
            return;
        end
        hist.push_front(sig);
        void'(hist.pop_back());
        s_now  = hist[SYNC];
        s_prev = hist[SYNC + 1];

        if (m_pend != '0 && !bus_if.fifo_full) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (m_last + k) % NUM_CH;
                if (m_pend[c]) begin
                    exp_q.push_back(m_rec[c]);
                    m_hold    = m_rec[c];
                    m_pend[c] = 1'b0;
                    m_last    = c;
                    m_wr      = 1'b1;
                    break;
                end
            end
        end

        op = bus_if.cmd_in[63:60];
        m  = bus_if.valid ? bus_if.cmd_in[NUM_CH-1:0] : '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (m_mode[i])
                0:       h = s_now[i] && !s_prev[i];
                1:       h = !s_now[i] && s_prev[i];
                default: h = s_now[i] != s_prev[i];
            endcase
            if (m[i] && (op == 4'h2 || op == 4'h3)) begin
                m_rec[i]  = make_rec(bus_if.counter, i, m_sat[i], m_pend[i], m_mode[i], m_count[i]);
                m_pend[i] = 1'b1;
            end
            if (m[i] && (op == 4'h1 || op == 4'h2 || op == 4'h4)) begin
                m_count[i] = 0;
                m_sat[i]   = 0;
            end else if (m_armed[i] && h) begin
                if (m_count[i] == CNT_MAX) m_sat[i] = 1;
                else m_count[i]++;
            end
            if (m[i] && op == 4'h1) m_armed[i] = 1;
            if (m[i] && op == 4'h2) m_armed[i] = 0;
            if (m[i] && op == 4'h5) m_mode[i] = int'(bus_if.cmd_in[17:16]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        bus_if.valid   = 1'b0;
        bus_if.counter = bus_if.counter + 64'd1;
    endtask

    task automatic send(input logic [3:0] op, input logic [15:0] mask, input logic [1:0] mode);
        bus_if.cmd_in = {op, 42'd0, mode, mask};
        bus_if.valid  = 1'b1;
        tick();
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] m, input int hi, input int lo);
        sig = sig | m;
        repeat (hi) tick();
        sig = sig & ~m;
        repeat (lo) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sig = '0;
        bus_if.fifo_full = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        tick();
        while ((exp_q.size() != 0 || m_pend != '0) && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || m_pend != '0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: %0d records still outstanding, required 0", name, exp_q.size());
        end
    endtask

    // Monitor: every cycle check strobe/busy/hold, pop scoreboard on each write
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cyc++;
                chk("write", 128'(bus_if.write), 128'(m_wr));
                chk("busy", 128'(bus_if.busy), 128'(|m_pend));
                if (bus_if.write) begin
                    got_q.push_back(bus_if.count_out);
                    got_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_write: got %h required no write", bus_if.count_out);
                    end else begin
                        chk("record", bus_if.count_out, exp_q.pop_front());
                    end
                end else begin
                    chk("hold", bus_if.count_out, m_hold);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sig = '0;
        bus_if.cmd_in = '0;
        bus_if.valid = 1'b0;
        bus_if.counter = '0;
        bus_if.fifo_full = 1'b0;
        tick();
        chk_en = 1'b1;
        do_reset();
        chk("reset_write", 128'(bus_if.write), 128'(0));
        chk("reset_count_out", bus_if.count_out, 128'(0));
        chk("reset_busy", 128'(bus_if.busy), 128'(0));

        // 1: five rising edges between START and STOP
        bus_if.counter = 64'd100;
        send(4'h1, 16'h1, 2'b00);
        repeat (5) pulse(4'h1, 2, 2);
        repeat (4) tick();
        bus_if.counter = 64'd200;
        send(4'h2, 16'h1, 2'b00);
        wait_idle("t1");
        chk("t1_nwrites", 128'(got_q.size()), 128'(1));
        if (got_q.size() == 1) chk("t1_rec", got_q[0], make_rec(200, 0, 0, 0, 0, 5));

        // 2: both-edge mode, snapshot mid-run
        do_reset();
        send(4'h5, 16'h2, 2'b10);
        send(4'h1, 16'h2, 2'b00);
        repeat (3) pulse(4'h2, 2, 2);
        repeat (4) tick();
        bus_if.counter = 64'd300;
        send(4'h3, 16'h2, 2'b00);
        pulse(4'h2, 2, 2);
        repeat (4) tick();
        bus_if.counter = 64'd400;
        send(4'h2, 16'h2, 2'b00);
        wait_idle("t2");
        chk("t2_nwrites", 128'(got_q.size()), 128'(2));
        if (got_q.size() == 2) begin
            chk("t2_snap", got_q[0], make_rec(300, 1, 0, 0, 2, 6));
            chk("t2_stop", got_q[1], make_rec(400, 1, 0, 0, 2, 8));
        end

        // 3: saturation of a 4-bit counter
        do_reset();
        send(4'h1, 16'h1, 2'b00);
        repeat (20) pulse(4'h1, 1, 1);
        repeat (4) tick();
        bus_if.counter = 64'd500;
        send(4'h2, 16'h1, 2'b00);
        wait_idle("t3");
        chk("t3_nwrites", 128'(got_q.size()), 128'(1));
        if (got_q.size() == 1) chk("t3_rec", got_q[0], make_rec(500, 0, 1, 0, 0, 15));

        // 4: STOP on all channels drains in order on consecutive cycles
        do_reset();
        send(4'h1, 16'hF, 2'b00);
        for (int p = 0; p < NUM_CH; p++) pulse(4'(4'hF << p), 2, 2);
        repeat (4) tick();
        bus_if.counter = 64'd600;
        send(4'h2, 16'hF, 2'b00);
        wait_idle("t4");
        chk("t4_nwrites", 128'(got_q.size()), 128'(4));
        if (got_q.size() == 4) begin
            for (int i = 0; i < NUM_CH; i++) begin
                chk("t4_rec", got_q[i], make_rec(600, i, 0, 0, 0, i + 1));
                chk("t4_gap", 128'(got_cyc[i] - got_cyc[0]), 128'(i));
            end
        end

        // 5: overwrite under backpressure sets lost
        do_reset();
        bus_if.fifo_full = 1'b1;
        bus_if.counter = 64'd700;
        send(4'h3, 16'h4, 2'b00);
        repeat (2) tick();
        bus_if.counter = 64'd710;
        send(4'h3, 16'h4, 2'b00);
        repeat (5) tick();
        chk("t5_no_write", 128'(got_q.size()), 128'(0));
        chk("t5_busy", 128'(bus_if.busy), 128'(1));
        bus_if.fifo_full = 1'b0;
        wait_idle("t5");
        chk("t5_nwrites", 128'(got_q.size()), 128'(1));
        if (got_q.size() == 1) chk("t5_rec", got_q[0], make_rec(710, 2, 0, 1, 0, 0));

        // 6: reset discards a pending record
        do_reset();
        send(4'h1, 16'h8, 2'b00);
        repeat (2) pulse(4'h8, 2, 2);
        repeat (4) tick();
        bus_if.fifo_full = 1'b1;
        bus_if.counter = 64'd800;
        send(4'h2, 16'h8, 2'b00);
        repeat (3) tick();
        chk("t6_busy_before", 128'(bus_if.busy), 128'(1));
        rst = 1'b1;
        tick();
        chk("t6_busy_after", 128'(bus_if.busy), 128'(0));
        chk("t6_write_after", 128'(bus_if.write), 128'(0));
        rst = 1'b0;
        bus_if.fifo_full = 1'b0;
        repeat (5) tick();
        chk("t6_discarded", 128'(got_q.size()), 128'(0));
        bus_if.counter = 64'd900;
        send(4'h2, 16'h8, 2'b00);
        wait_idle("t6");
        chk("t6_nwrites", 128'(got_q.size()), 128'(1));
        if (got_q.size() == 1) chk("t6_rec", got_q[0], make_rec(900, 3, 0, 0, 0, 0));

        // Random traffic against the model
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < NUM_CH; b++) begin
                if ($urandom_range(3) == 0) sig[b] = ~sig[b];
            end
            bus_if.fifo_full = ($urandom_range(2) == 0);
            rst = ($urandom_range(599) == 0);
            if ($urandom_range(4) == 0) begin
                bus_if.cmd_in = {4'($urandom_range(7)), 42'($urandom), 2'($urandom_range(3)),
                                 16'($urandom)};
                bus_if.valid = 1'b1;
            end
            tick();
        end
        rst = 1'b0;
        bus_if.fifo_full = 1'b0;
        wait_idle("random");
        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_counter_multi.md
Name: edge_counter_multi

Overview:
Next-generation gated edge counter: NUM_CH independent input channels, each with a selectable edge mode, counted between timestamped START/STOP commands.
- Commands arrive as 64-bit words from the GPO output path (cmd_in/valid, same timing as the existing single-channel controller).
- Each emit produces one 128-bit record written into the RTI input FIFO, with backpressure from the FIFO full flag.
- Sits between GPO_Core and RTI_Core inside an EdgeCounter-class top.

Parameters:
NUM_CH, 4, number of input channels (1..16)
COUNT_WIDTH, 32, per-channel counter width (1..48)
SYNC_STAGES, 2, synchroniser flops per input (>=2)

Ports:
clk  input  1  system clock (s_axi_aclk domain)
reset  input  1  synchronous, active-high reset
input_sig  input  NUM_CH  asynchronous signals to count
cmd_in  input  64  command word
valid  input  1  cmd_in qualifier, one-cycle pulse
counter  input  64  global timestamp
fifo_full  input  1  RTI FIFO full
write  output  1  RTI FIFO write strobe
count_out  output  128  record to RTI FIFO
busy  output  1  any emit pending

Behaviour:
- Reset, synchronous, active-high, clk rising edge:
  - write=0, count_out=0, busy=0.
  - All counts 0, all channels disarmed, mode=RISING, pending/lost/sat flags 0, synchroniser flops 0.
  - A reset mid-operation discards pending records without writing them.
- Input path:
  - SYNC_STAGES flops, then a 1-flop edge detector.
  - An edge is counted SYNC_STAGES+1 cycles after the input transition.
- Edge modes, cmd bits [17:16]:
  - 00 RISING, 01 FALLING, 10 BOTH, 11 treated as BOTH.
- Command decode, only when valid=1:
  - Opcode = cmd_in[63:60]; channel mask = cmd_in[NUM_CH-1:0]; mask bits >= NUM_CH are ignored.
  - 0x1 START: arm masked channels, count:=0, sat:=0.
  - 0x2 STOP: disarm masked channels, emit record, then count:=0.
  - 0x3 SNAPSHOT: emit record; counting continues uninterrupted.
  - 0x4 CLEAR: count:=0, sat:=0; arm state unchanged; no emit.
  - 0x5 SET_MODE: set mode for masked channels; count unchanged.
  - All other opcodes are ignored.
- Counting:
  - An armed channel increments by 1 per qualifying edge.
  - At all-ones the count saturates and sat:=1.
  - An edge in the same cycle as START/CLEAR/STOP is discarded.
  - SNAPSHOT captures the count before that cycle's edge; the edge still counts.
- Emit capture:
  - Per channel, one pending slot holds {counter at command cycle, count, sat, mode}.
  - Emit into an occupied slot overwrites it and sets lost:=1 in that slot.
- Output arbiter:
  - Round-robin over pending slots, starting after the last served channel; at most 1 write per cycle.
  - write=1 only when fifo_full=0.
  - write and count_out are registered: 1 cycle after capture at the earliest.
  - A slot is freed on the cycle its write=1.
  - busy = OR of pending slots.
- Record count_out:
  - [127:64] timestamp
  - [63:60] channel index
  - [59] sat
  - [58] lost
  - [57:56] mode
  - [COUNT_WIDTH-1:0] count
  - All other bits 0.
- count_out holds its last value when write=0.

Decomposition:
- Package edge_counter_pkg:
  - opcode enum (ec_op_t)
  - edge mode enum (ec_mode_t)
  - record field offset localparams
  - record packed struct
- Sub-module ec_channel: synchroniser, edge detect, counter, pending slot; instantiated NUM_CH times in a generate loop.
- The top level holds the command decode and the round-robin arbiter.

Test Plan:
1. START ch0 at counter=100; apply 5 rising edges; STOP at counter=200 -> one write; count_out={64'd200, ch 0, sat=0, lost=0, mode=00, count=5}.
2. SET_MODE BOTH on ch1; START; 3 full pulses; SNAPSHOT; 1 more pulse; STOP -> two records with count 6 then 8.
3. COUNT_WIDTH=4; START; 20 edges; STOP -> count=15, sat=1.
4. STOP with mask 0xF while all four channels are armed -> four writes on consecutive cycles, channel order 0,1,2,3, each with the same timestamp.
5. Hold fifo_full=1; SNAPSHOT ch2 twice -> no write, busy=1; release fifo_full -> exactly one write with lost=1, carrying the second timestamp.
6. Assert reset while a record is pending -> write stays 0, busy=0 on the next cycle; a subsequent STOP without START emits count=0.
